// File: rtl/pipe_stage_buf_pkg.sv
// rtl/pipe_stage_buf_pkg.sv - shared lane width and slot layout for pipeline stage buffers
package pipe_stage_buf_pkg;

  localparam int MACHINE_WIDTH = 2;
  localparam int SLOT_DATA_W   = 32;

  // Stage-specific payload types live in their own stage packages; this is the generic carrier.
  typedef struct packed {
    logic [MACHINE_WIDTH-1:0]             lane_valid;
    logic [MACHINE_WIDTH*SLOT_DATA_W-1:0] payload;
  } slot_t;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - upstream/downstream slot handshake bundle
interface pipe_stage_buf_if
  import pipe_stage_buf_pkg::*;
#(
  parameter int LANES  = MACHINE_WIDTH,
  parameter int DATA_W = 32
);

  logic                    in_valid;
  logic [LANES-1:0]        in_lane_valid;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_ready;

  logic                    out_valid;
  logic [LANES-1:0]        out_lane_valid;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    out_ready;

  modport slave (
    input  in_valid, in_lane_valid, in_data, out_ready,
    output in_ready, out_valid, out_lane_valid, out_data
  );

  modport master (
    output in_valid, in_lane_valid, in_data, out_ready,
    input  in_ready, out_valid, out_lane_valid, out_data
  );

endinterface

// File: rtl/pipe_slot_reg.sv
// rtl/pipe_slot_reg.sv - one slot register with synchronous clear and load enables
module pipe_slot_reg #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_ld,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_reset || i_clr) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-slot skid buffer between pipeline stages
// PIPE_STAGE_BUF_BYPASS_EN: forward input straight to output while empty.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int LANES  = MACHINE_WIDTH,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_buf_if.slave  bus,
  output logic [1:0]       count
);

  localparam int SLOT_W = LANES + LANES*DATA_W;

  logic [1:0]        r_count;
  logic [1:0]        w_count_nxt;
  logic [SLOT_W-1:0] w_in_slot;
  logic [SLOT_W-1:0] w_main_q;
  logic [SLOT_W-1:0] w_skid_q;
  logic [SLOT_W-1:0] w_main_d;
  logic              w_main_ld;
  logic              w_skid_ld;
  logic              w_push;
  logic              w_pop;
  logic              w_store;
  logic              w_bypass;

  assign w_in_slot   = {bus.in_lane_valid, bus.in_data};
  assign bus.in_ready = (r_count != 2'd2);

  // Bubbles are accepted on the handshake but never occupy a slot.
  assign w_push = bus.in_valid && bus.in_ready && (|bus.in_lane_valid) && !flush;
  assign w_pop  = bus.out_ready && (r_count != 2'd0);

`ifdef PIPE_STAGE_BUF_BYPASS_EN
  assign w_bypass = (r_count == 2'd0) && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed slot taken downstream in the same cycle is never stored.
  assign w_store = w_push && !(w_bypass && bus.out_ready);

  always_comb begin
    bus.out_valid      = (r_count != 2'd0);
    bus.out_lane_valid = w_main_q[SLOT_W-1 -: LANES];
    bus.out_data       = w_main_q[LANES*DATA_W-1:0];
    if (w_bypass) begin
      bus.out_valid      = bus.in_valid && (|bus.in_lane_valid);
      bus.out_lane_valid = bus.in_lane_valid;
      bus.out_data       = bus.in_data;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    w_main_ld   = 1'b0;
    w_skid_ld   = 1'b0;
    w_main_d    = w_in_slot;
    if (flush) begin
      w_count_nxt = 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_store) begin
            w_main_ld   = 1'b1;
            w_count_nxt = 2'd1;
          end
        end
        2'd1: begin
          if (w_store && w_pop) begin
            w_main_ld = 1'b1;
          end else if (w_store) begin
            w_skid_ld   = 1'b1;
            w_count_nxt = 2'd2;
          end else if (w_pop) begin
            w_count_nxt = 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            w_main_ld   = 1'b1;
            w_main_d    = w_skid_q;
            w_count_nxt = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  pipe_slot_reg #(.W(SLOT_W)) u_main (
    .clk     (clk),
    .i_reset (reset),
    .i_clr   (flush),
    .i_ld    (w_main_ld),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  pipe_slot_reg #(.W(SLOT_W)) u_skid (
    .clk     (clk),
    .i_reset (reset),
    .i_clr   (flush),
    .i_ld    (w_skid_ld),
    .i_d     (w_in_slot),
    .o_q     (w_skid_q)
  );

  assign count = r_count;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - queue-model checked bench for pipe_stage_buf
module tb_pipe_stage_buf;
  import pipe_stage_buf_pkg::*;

  localparam int LANES  = MACHINE_WIDTH;
  localparam int DATA_W = SLOT_DATA_W;
  localparam int DW     = LANES*DATA_W;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [1:0] count;

  pipe_stage_buf_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

  pipe_stage_buf #(.LANES(LANES), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave),
    .count (count)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  slot_t model_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, compare against the queue model, then advance it.
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [LANES-1:0] lv, input logic [DW-1:0] d,
                       input logic ordy, input bit chk);
    int    sz;
    bit    byp;
    bit    pop;
    bit    push;
    bit    live;
    slot_t s;
    reset             = rst;
    flush             = fl;
    bus.in_valid      = iv;
    bus.in_lane_valid = lv;
    bus.in_data       = d;
    bus.out_ready     = ordy;
    #1;
    sz   = model_q.size();
    live = iv && (lv != '0);
    byp  = 1'b0;
`ifdef PIPE_STAGE_BUF_BYPASS_EN
    byp = (sz == 0) && !fl;
`endif
    if (chk) begin
      check("count", count, sz);
      check("count_range", count <= 2'd2, 1);
      check("in_ready", bus.in_ready, sz != 2);
      if (byp) begin
        check("out_valid_byp", bus.out_valid, live);
        if (live) begin
          check("out_lane_valid_byp", bus.out_lane_valid, lv);
          check("out_data_byp", bus.out_data, d);
        end
      end else begin
        check("out_valid", bus.out_valid, sz != 0);
        if (sz != 0) begin
          check("out_lane_valid", bus.out_lane_valid, model_q[0].lane_valid);
          check("out_data", bus.out_data, model_q[0].payload);
        end
      end
    end
    @(posedge clk);
    if (rst || fl) begin
      model_q.delete();
    end else begin
      pop  = ordy && (sz != 0);
      push = live && (sz != 2) && !(byp && ordy);
      if (pop) void'(model_q.pop_front());
      if (push) begin
        s.lane_valid = lv;
        s.payload    = d;
        model_q.push_back(s);
      end
    end
    @(negedge clk);
  endtask

  logic [DW-1:0] slot_a;
  logic [DW-1:0] slot_b;
  logic [DW-1:0] slot_c;

  initial begin
    slot_a = 64'h0000_0000_1111_2222;
    slot_b = 64'h3333_4444_5555_6666;
    slot_c = 64'h7777_8888_9999_aaaa;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_lane_valid = '0;
    bus.in_data       = '0;
    bus.out_ready     = 1'b0;
    @(negedge clk);

    cycle(1, 0, 0, 2'b00, '0, 0, 0);
    cycle(1, 0, 0, 2'b00, '0, 0, 1);
    check("rst_count", count, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_lane_valid", bus.out_lane_valid, 0);
    check("rst_out_data", bus.out_data, 0);

    cycle(0, 0, 1, 2'b11, slot_a, 1, 1);
`ifdef PIPE_STAGE_BUF_BYPASS_EN
    check("byp_count_a", count, 0);
`else
    check("lat_count_a", count, 1);
    check("lat_valid_a", bus.out_valid, 1);
    check("lat_data_a", bus.out_data, slot_a);
`endif
    cycle(0, 0, 0, 2'b00, '0, 1, 1);
    check("drain_count", count, 0);

    cycle(0, 0, 1, 2'b11, slot_a, 0, 1);
    cycle(0, 0, 1, 2'b01, slot_b, 0, 1);
    check("full_count", count, 2);
    check("full_in_ready", bus.in_ready, 0);
    cycle(0, 0, 1, 2'b10, slot_c, 0, 1);
    check("refused_count", count, 2);
    check("refused_head", bus.out_data, slot_a);
    cycle(0, 0, 1, 2'b10, slot_c, 1, 1);
    check("second_head", bus.out_data, slot_b);
    check("second_count", count, 1);
    cycle(0, 0, 1, 2'b10, slot_c, 1, 1);
    check("third_head", bus.out_data, slot_c);
    check("third_lane_valid", bus.out_lane_valid, 2'b10);
    cycle(0, 0, 0, 2'b00, '0, 1, 1);

    cycle(0, 0, 1, 2'b11, slot_a, 0, 1);
    cycle(0, 0, 1, 2'b11, slot_b, 0, 1);
    cycle(0, 1, 1, 2'b11, slot_c, 0, 1);
    check("flush_count", count, 0);
    check("flush_in_ready", bus.in_ready, 1);
    check("flush_out_valid", bus.out_valid, 0);

    cycle(0, 0, 1, 2'b00, slot_b, 0, 1);
    check("bubble_count", count, 0);
    check("bubble_out_valid", bus.out_valid, 0);

    for (int i = 0; i < 10000; i++) begin
      cycle($urandom_range(499) == 0,
            $urandom_range(19) == 0,
            $urandom_range(9) < 7,
            LANES'($urandom_range(3)),
            {$urandom, $urandom},
            $urandom_range(9) < 6,
            1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
